// File: rtl/pe_accum_drain.sv
// rtl/pe_accum_drain.sv - window control, bias, saturation and drain around one PE MAC
// Optional ReLU after saturation when PE_DRAIN_RELU_EN is defined.
module pe_accum_drain #(
   parameter int DATA_WIDTH  = 16,
   parameter int KERNEL_SIZE = 25
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mac_valid,
   output logic                  mac_ready,
   input  logic [DATA_WIDTH-1:0] a_in,
   input  logic [DATA_WIDTH-1:0] b_in,
   input  logic [DATA_WIDTH-1:0] bias,
   output logic [DATA_WIDTH-1:0] pe_a,
   output logic [DATA_WIDTH-1:0] pe_b,
   output logic                  pe_clear,
   input  logic [DATA_WIDTH-1:0] pe_result,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data
);

   localparam int CW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(KERNEL_SIZE - 1);

   typedef enum logic [1:0] {CLEAR, ACCUM, CAPTURE} state_t;

   state_t                  state;
   logic [CW-1:0]           cnt;
   logic                    accept;
   logic [DATA_WIDTH:0]     sum;
   logic [DATA_WIDTH-1:0]   sat;
   logic [DATA_WIDTH-1:0]   act;

   assign mac_ready = (state == ACCUM) && !reset;
   assign accept    = mac_valid && mac_ready;

   // The PE accumulates every clock, so idle cycles must present a zero product.
   assign pe_a = accept ? a_in : '0;
   assign pe_b = accept ? b_in : '0;

   always_comb begin
      sum = {pe_result[DATA_WIDTH-1], pe_result} + {bias[DATA_WIDTH-1], bias};
      if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])
         sat = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                               : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else
         sat = sum[DATA_WIDTH-1:0];
`ifdef PE_DRAIN_RELU_EN
      act = sat[DATA_WIDTH-1] ? '0 : sat;
`else
      act = sat;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= CLEAR;
         pe_clear  <= 1'b1;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         case (state)
            CLEAR: begin
               pe_clear <= 1'b0;
               state    <= ACCUM;
            end
            ACCUM: begin
               if (accept) begin
                  if (cnt == CNT_LAST) begin
                     cnt   <= '0;
                     state <= CAPTURE;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            CAPTURE: begin
               // Reload in the same cycle the previous pixel is taken, so no bubble.
               if (!(out_valid && !out_ready)) begin
                  out_data  <= act;
                  out_valid <= 1'b1;
                  pe_clear  <= 1'b1;
                  state     <= CLEAR;
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

endmodule

// File: tb/tb_pe_accum_drain.sv
// tb/tb_pe_accum_drain.sv - directed bench for pe_accum_drain with a behavioural PE MAC model
module tb_pe_accum_drain;

   logic        clk = 1'b0;
   logic        reset;
   logic        mac_valid;
   logic        mac_ready;
   logic [15:0] a_in, b_in, bias;
   logic [15:0] pe_a, pe_b;
   logic        pe_clear;
   logic [15:0] pe_result;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;

   int n_vec  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int n_clr  = 0;
   int n_ov   = 0;
   logic [15:0] q_data[$];
   int          q_cyc[$];

`ifdef PE_DRAIN_RELU_EN
   localparam int EXP_NEG = 0;
   localparam int EXP_MIN = 0;
`else
   localparam int EXP_NEG = -6400;
   localparam int EXP_MIN = -32768;
`endif

   pe_accum_drain #(.DATA_WIDTH(16), .KERNEL_SIZE(25)) dut (
      .clk(clk), .reset(reset), .mac_valid(mac_valid), .mac_ready(mac_ready),
      .a_in(a_in), .b_in(b_in), .bias(bias), .pe_a(pe_a), .pe_b(pe_b),
      .pe_clear(pe_clear), .pe_result(pe_result), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data)
   );

   always #5 clk = ~clk;

   // PE model: wide accumulator, synchronous clear, result = acc >> 8
   logic signed [47:0] pe_acc;
   logic signed [31:0] prod;
   assign prod      = $signed(pe_a) * $signed(pe_b);
   assign pe_result = pe_acc[23:8];
   always @(posedge clk) begin
      if (pe_clear) pe_acc <= '0;
      else          pe_acc <= pe_acc + {{16{prod[31]}}, prod};
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         q_data.push_back(out_data);
         q_cyc.push_back(cyc);
      end
      if (pe_clear)  n_clr = n_clr + 1;
      if (out_valid) n_ov  = n_ov + 1;
   end

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_vec = n_vec + 1;
      assert (obs === exp) else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic feed(input int n, input logic [15:0] a, input logic [15:0] b,
                       input bit gaps, output int cycles);
      int  accepted = 0;
      bit  tog = 1'b1;
      cycles = 0;
      while (accepted < n && cycles < 2000) begin
         mac_valid = gaps ? tog : 1'b1;
         a_in = a;
         b_in = b;
         #1;
         if (mac_valid && mac_ready) accepted++;
         if (gaps && !mac_valid) begin
            check("gap_pe_a", 32'(pe_a), 0);
            check("gap_pe_b", 32'(pe_b), 0);
         end
         @(posedge clk);
         #1;
         cycles++;
         tog = ~tog;
      end
      mac_valid = 1'b0;
      if (accepted < n) check("feed_timeout", accepted, n);
   endtask

   initial begin
      int cycles, base, cbase, obase;

      reset = 1'b1; mac_valid = 1'b0; a_in = '0; b_in = '0;
      bias = 16'd100; out_ready = 1'b1;
      tick(3);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_mac_ready", 32'(mac_ready), 0);
      check("rst_pe_clear",  32'(pe_clear), 1);
      check("rst_out_data",  32'(out_data), 0);
      reset = 1'b0;
      #1;
      check("rel_pe_clear",  32'(pe_clear), 1);
      check("rel_mac_ready", 32'(mac_ready), 0);
      tick(1);
      check("accum_ready",   32'(mac_ready), 1);
      mac_valid = 1'b1; a_in = 16'd512; b_in = 16'd256;
      #1;
      check("pass_pe_a", 32'(pe_a), 512);
      mac_valid = 1'b0;
      #1;
      check("idle_pe_a", 32'(pe_a), 0);

      // two back-to-back windows, no backpressure
      base = q_data.size(); cbase = n_clr; obase = n_ov;
      feed(50, 16'd512, 16'd256, 1'b0, cycles);
      tick(5);
      check("two_win_count", q_data.size() - base, 2);
      if (q_data.size() >= base + 2) begin
         check("win1_data",   32'($signed(q_data[base])), 12900);
         check("win2_data",   32'($signed(q_data[base+1])), 12900);
         check("pixel_period", q_cyc[base+1] - q_cyc[base], 27);
      end
      check("pe_clear_cycles", n_clr - cbase, 2);
      check("out_valid_cycles", n_ov - obase, 2);

      // one pair every other cycle
      base = q_data.size();
      feed(25, 16'd512, 16'd256, 1'b1, cycles);
      check("gap_cycles", cycles, 49);
      tick(4);
      check("gap_count", q_data.size() - base, 1);
      if (q_data.size() > base) check("gap_data", 32'($signed(q_data[base])), 12900);

      // backpressure across two windows
      out_ready = 1'b0;
      feed(25, 16'd512, 16'd256, 1'b0, cycles);
      tick(3);
      check("bp_valid1", 32'(out_valid), 1);
      check("bp_data1",  32'($signed(out_data)), 12900);
      bias = 16'd200;
      feed(25, 16'd512, 16'd256, 1'b0, cycles);
      tick(2);
      mac_valid = 1'b1;
      #1;
      check("bp_stall_ready", 32'(mac_ready), 0);
      check("bp_stall_pe_a",  32'(pe_a), 0);
      check("bp_stall_pe_b",  32'(pe_b), 0);
      check("bp_hold_data",   32'($signed(out_data)), 12900);
      tick(3);
      check("bp_hold_data2",  32'($signed(out_data)), 12900);
      check("bp_hold_valid",  32'(out_valid), 1);
      mac_valid = 1'b0;
      base = q_data.size();
      out_ready = 1'b1;
      tick(3);
      check("bp_drain_count", q_data.size() - base, 2);
      if (q_data.size() >= base + 2) begin
         check("bp_drain1", 32'($signed(q_data[base])), 12900);
         check("bp_drain2", 32'($signed(q_data[base+1])), 13000);
         check("bp_no_bubble", q_cyc[base+1] - q_cyc[base], 1);
      end

      // positive overflow: pe_result 32700 + 100
      bias = 16'd100;
      base = q_data.size();
      feed(25, 16'd1308, 16'd256, 1'b0, cycles);
      tick(4);
      check("ovf_count", q_data.size() - base, 1);
      if (q_data.size() > base) check("ovf_pos", 32'($signed(q_data[base])), 32767);

      // negative overflow: pe_result -100 + -32768
      bias = 16'h8000;
      base = q_data.size();
      feed(25, 16'hFFFC, 16'd256, 1'b0, cycles);
      tick(4);
      if (q_data.size() > base) check("ovf_neg", 32'($signed(q_data[base])), EXP_MIN);
      else check("ovf_neg_count", q_data.size() - base, 1);

      // negative window
      bias = 16'd0;
      base = q_data.size();
      feed(25, 16'hFF00, 16'd256, 1'b0, cycles);
      tick(4);
      if (q_data.size() > base) check("neg_win", 32'($signed(q_data[base])), EXP_NEG);
      else check("neg_win_count", q_data.size() - base, 1);

      // reset after a partial window
      bias = 16'd100;
      base = q_data.size();
      feed(10, 16'd512, 16'd256, 1'b0, cycles);
      reset = 1'b1;
      mac_valid = 1'b1;
      #1;
      check("mid_rst_ready", 32'(mac_ready), 0);
      tick(1);
      check("mid_rst_valid", 32'(out_valid), 0);
      check("mid_rst_data",  32'(out_data), 0);
      check("mid_rst_clear", 32'(pe_clear), 1);
      tick(1);
      reset = 1'b0;
      mac_valid = 1'b0;
      #1;
      check("mid_rel_clear", 32'(pe_clear), 1);
      check("mid_rel_ready", 32'(mac_ready), 0);
      check("mid_partial_dropped", q_data.size() - base, 0);
      tick(1);
      feed(25, 16'd512, 16'd256, 1'b0, cycles);
      tick(4);
      check("post_rst_count", q_data.size() - base, 1);
      if (q_data.size() > base) check("post_rst_data", 32'($signed(q_data[base])), 12900);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
